lookup_cfg_writer: RTL and testbench
====================================

Name: lookup_cfg_writer

Overview:
- Control-plane initiator for one match stage's table write ports.
- Consumes AXI-Stream control packets and decodes a per-stage header. Packets addressed to this stage are assembled into full-width writes.
- Drives the CAM entry write port (data, mask, addr, en) and the action RAM write port (data, addr, en) of the lookup engine instance with the same STAGE value.
- Packets for other stages are drained silently.

Parameters:
STAGE, 0, stage ID this writer responds to; compared against header byte.
DATA_W, 256, s_axis beat width; fixed at 256, other values unsupported.
ENTRY_W, 1024, CAM entry and mask width; must equal 4*DATA_W.
ACT_W, 25, action RAM word width.
ADDR_W, 4, table address width (16 entries).

Ports:
axis_clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  256  control packet beat
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accepted when tvalid&tready
s_axis_tlast  in  1  last beat of packet
lookup_din  out  1024  CAM entry key data
lookup_din_mask  out  1024  CAM entry mask
lookup_din_addr  out  4  CAM write address
lookup_din_en  out  1  CAM write strobe, one cycle
action_data_in  out  25  action RAM write data
action_addr  out  4  action RAM write address
action_en  out  1  action RAM write strobe, one cycle
cfg_wr_cnt  out  16  committed writes, wraps
cfg_err_cnt  out  16  malformed packets for this stage, wraps

Behaviour:
- Interface: reset aresetn, asynchronous, active-low; clock axis_clk.
- Reset values:
  - All outputs 0, except s_axis_tready = 1.
  - FSM state = IDLE; beat counter = 0.
- Header (first beat): tdata[7:0] = stage, [11:8] = type (0 = CAM entry, 1 = action), [15:12] = addr; remaining bits ignored.
- CAM packet: header followed by 8 payload beats.
  - Beats 1-4 form lookup_din; beat k (k = 0..3) goes to bits [256k+255:256k].
  - Beats 5-8 form lookup_din_mask in the same order.
- Action packet: header followed by 1 payload beat; tdata[24:0] = action_data_in.
- States:
  - IDLE: on accepted beat, latch type/addr.
    - stage != STAGE: go to DRAIN if !tlast, else stay in IDLE. No error.
    - stage == STAGE, tlast = 1, or type > 1: err++; go to DRAIN if !tlast, else IDLE.
    - Otherwise: type 0 -> CAM_DATA (cnt = 0); type 1 -> ACT_DATA.
  - CAM_DATA: each accepted beat is stored at index cnt; cnt++. After the 4th beat go to CAM_MASK with cnt = 0.
  - CAM_MASK: same as CAM_DATA, writing into the mask register.
  - ACT_DATA: store beat.
  - Final required beat (CAM_MASK beat 4 or ACT_DATA beat):
    - tlast = 1: go to COMMIT.
    - tlast = 0: packet too long. err++, go to DRAIN, no write.
  - Early tlast (any payload beat before the final one): err++, go to IDLE, no write. Partial data is not committed and the write strobes stay low.
  - DRAIN: accept beats until tlast, then go to IDLE.
  - COMMIT:
    - s_axis_tready = 0 (only state with tready low).
    - Assert lookup_din_en, or action_en, for exactly one cycle, with addr/data/mask stable that cycle.
    - cfg_wr_cnt++; next state IDLE.
- Latency: write strobe asserted in the cycle after the final payload beat is accepted. Minimum inter-packet gap is 1 cycle (COMMIT).
- Data, mask and addr outputs hold their last committed values after COMMIT. Only the strobe is pulsed.
- Payload assembly uses internal shadow registers. The lookup_din, lookup_din_mask and action_data_in outputs change only in COMMIT, so an aborted packet never disturbs them.
- tvalid low mid-packet: state and cnt hold; no timeout.
- Counters wrap at 16'hFFFF -> 0.
- aresetn asserted mid-packet: immediate return to IDLE. Partial data discarded, no strobe. The remainder of that packet is parsed as a new header after reset release; the upstream side must also reset.

Test Plan:
- Action write: header stage = 0, type = 1, addr = 3; payload 25'h1ABCDE with tlast -> action_en = 1 for 1 cycle, 1 cycle after the payload beat, with action_addr = 3 and data = 25'h1ABCDE. cfg_wr_cnt = 1; lookup_din_en stays 0.
- CAM write: header type = 0, addr = 15; 4 data beats {D0..D3}, 4 mask beats {M0..M3}, tlast on beat 8 -> lookup_din = {D3,D2,D1,D0}, mask = {M3,M2,M1,M0}, addr = 15, lookup_din_en pulses once; tready = 0 in that cycle only.
- Foreign stage: header stage = 5 (STAGE = 0), 9 beats -> no strobes; both counters unchanged; all beats accepted.
- Early tlast on CAM data beat 2 -> no strobe; cfg_err_cnt = 1; the next valid action packet commits normally.
- Too-long action packet (3 beats, tlast on beat 3) -> no write, err = 1, beat 3 drained; outputs keep their prior values.
- Backpressure/reset: tvalid toggled 50% during a CAM packet -> identical result to back-to-back beats. A separate CAM packet with aresetn pulsed after beat 4 -> no strobe, and all outputs (and internal state) return to reset values.

Source files
------------

// File: rtl/lookup_cfg_writer.sv
// Control-plane writer for one match stage: decodes AXI-Stream config packets and
// turns those addressed to STAGE into single-cycle CAM-entry or action-RAM writes.
module lookup_cfg_writer #(
    parameter int STAGE   = 0,
    parameter int DATA_W  = 256,
    parameter int ENTRY_W = 1024,
    parameter int ACT_W   = 25,
    parameter int ADDR_W  = 4
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [ENTRY_W-1:0] lookup_din,
    output logic [ENTRY_W-1:0] lookup_din_mask,
    output logic [ADDR_W-1:0]  lookup_din_addr,
    output logic               lookup_din_en,
    output logic [ACT_W-1:0]   action_data_in,
    output logic [ADDR_W-1:0]  action_addr,
    output logic               action_en,
    output logic [15:0]        cfg_wr_cnt,
    output logic [15:0]        cfg_err_cnt
);

    // Handshake: a beat transfers on a rising edge where s_axis_tvalid && s_axis_tready.
    // tready is low only in COMMIT, which gives the one-cycle inter-packet gap.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAM_DATA = 3'd1,
        CAM_MASK = 3'd2,
        ACT_DATA = 3'd3,
        DRAIN    = 3'd4,
        COMMIT   = 3'd5
    } state_t;

    localparam logic [7:0] STAGE_ID = 8'(STAGE);

    state_t              state, state_nxt;
    logic [1:0]          cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [ENTRY_W-1:0]  din_sh, mask_sh;
    logic                accept;
    logic                err_inc, commit_cam, commit_act;
    logic [7:0]          hdr_stage;
    logic [3:0]          hdr_type;

    assign s_axis_tready = (state != COMMIT);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign hdr_stage     = s_axis_tdata[7:0];
    assign hdr_type      = s_axis_tdata[11:8];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        err_inc    = 1'b0;
        commit_cam = 1'b0;
        commit_act = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hdr_stage != STAGE_ID) begin
                        state_nxt = s_axis_tlast ? IDLE : DRAIN;
                    end else if (s_axis_tlast || hdr_type > 4'd1) begin
                        err_inc   = 1'b1;
                        state_nxt = s_axis_tlast ? IDLE : DRAIN;
                    end else if (hdr_type == 4'd0) begin
                        state_nxt = CAM_DATA;
                        cnt_nxt   = 2'd0;
                    end else begin
                        state_nxt = ACT_DATA;
                    end
                end
            end
            CAM_DATA: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        err_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == 2'd3) begin
                        state_nxt = CAM_MASK;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            CAM_MASK: begin
                if (accept) begin
                    if (cnt == 2'd3) begin
                        if (s_axis_tlast) begin
                            commit_cam = 1'b1;
                            state_nxt  = COMMIT;
                        end else begin
                            err_inc   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        err_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            ACT_DATA: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        commit_act = 1'b1;
                        state_nxt  = COMMIT;
                    end else begin
                        err_inc   = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_tlast) state_nxt = IDLE;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && accept) addr_q <= s_axis_tdata[15:12];
        end
    end

    // Shadow registers collect the payload so the visible outputs only move on a commit.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            din_sh  <= '0;
            mask_sh <= '0;
        end else if (accept) begin
            if (state == CAM_DATA) din_sh[int'(cnt)*DATA_W +: DATA_W]  <= s_axis_tdata;
            if (state == CAM_MASK) mask_sh[int'(cnt)*DATA_W +: DATA_W] <= s_axis_tdata;
        end
    end

    // The final mask beat and the action word go straight from tdata into the outputs.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= '0;
            lookup_din_en   <= 1'b0;
            action_data_in  <= '0;
            action_addr     <= '0;
            action_en       <= 1'b0;
            cfg_wr_cnt      <= '0;
            cfg_err_cnt     <= '0;
        end else begin
            lookup_din_en <= 1'b0;
            action_en     <= 1'b0;
            if (commit_cam) begin
                lookup_din      <= din_sh;
                lookup_din_mask <= {s_axis_tdata, mask_sh[3*DATA_W-1:0]};
                lookup_din_addr <= addr_q;
                lookup_din_en   <= 1'b1;
            end
            if (commit_act) begin
                action_data_in <= s_axis_tdata[ACT_W-1:0];
                action_addr    <= addr_q;
                action_en      <= 1'b1;
            end
            if (commit_cam || commit_act) cfg_wr_cnt <= cfg_wr_cnt + 16'd1;
            if (err_inc) cfg_err_cnt <= cfg_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Directed bench for lookup_cfg_writer: expected commits are queued by the stimulus
// and checked by a monitor whenever a write strobe appears.
module tb_lookup_cfg_writer;

    logic           axis_clk;
    logic           aresetn;
    logic [255:0]   s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic           s_axis_tlast;
    logic [1023:0]  lookup_din;
    logic [1023:0]  lookup_din_mask;
    logic [3:0]     lookup_din_addr;
    logic           lookup_din_en;
    logic [24:0]    action_data_in;
    logic [3:0]     action_addr;
    logic           action_en;
    logic [15:0]    cfg_wr_cnt;
    logic [15:0]    cfg_err_cnt;

    lookup_cfg_writer #(.STAGE(0)) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .lookup_din      (lookup_din),
        .lookup_din_mask (lookup_din_mask),
        .lookup_din_addr (lookup_din_addr),
        .lookup_din_en   (lookup_din_en),
        .action_data_in  (action_data_in),
        .action_addr     (action_addr),
        .action_en       (action_en),
        .cfg_wr_cnt      (cfg_wr_cnt),
        .cfg_err_cnt     (cfg_err_cnt)
    );

    // ---------------- clock / reset ----------------
    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic          den;
        logic          aen;
        logic [3:0]    daddr;
        logic [1023:0] din;
        logic [1023:0] mask;
        logic [3:0]    aaddr;
        logic [24:0]   act;
        logic [15:0]   wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    time  last_acc_t = 0;

    logic [1023:0] m_din, m_mask;
    logic [3:0]    m_daddr, m_aaddr;
    logic [24:0]   m_act;
    logic [15:0]   m_wr, m_err;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic chk_wide(input string n, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            for (int k = 0; k < 4; k++) begin
                if (got[k*256 +: 256] !== exp[k*256 +: 256]) begin
                    $display("FAIL %s beat %0d: got %h expected %h", n, k,
                             got[k*256 +: 256], exp[k*256 +: 256]);
                    break;
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge axis_clk) begin
        if (aresetn && (lookup_din_en || action_en)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got cam_en=%b act_en=%b expected no strobe at %0t",
                         lookup_din_en, action_en, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cam_en", 64'(lookup_din_en), 64'(e.den));
                chk("act_en", 64'(action_en), 64'(e.aen));
                chk("cam_addr", 64'(lookup_din_addr), 64'(e.daddr));
                chk_wide("cam_din", lookup_din, e.din);
                chk_wide("cam_mask", lookup_din_mask, e.mask);
                chk("act_addr", 64'(action_addr), 64'(e.aaddr));
                chk("act_data", 64'(action_data_in), 64'(e.act));
                chk("wr_cnt", 64'(cfg_wr_cnt), 64'(e.wr));
                chk("tready_commit", 64'(s_axis_tready), 64'd0);
                chk("latency", 64'($time - last_acc_t), 64'd5);
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [255:0] hdr(input logic [7:0] st, input logic [3:0] ty,
                                         input logic [3:0] ad);
        logic [255:0] r;
        r = {15{16'hBEEF}} << 16;
        r[15:0] = {ad, ty, st};
        return r;
    endfunction

    function automatic logic [255:0] pat(input int s);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = {s[15:0], i[7:0], 8'hC3};
        return r;
    endfunction

    task automatic beat(input logic [255:0] d, input logic l, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            @(negedge axis_clk);
            s_axis_tvalid = 1'b0;
        end
        @(negedge axis_clk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        guard = 0;
        while (!s_axis_tready && guard < 20) begin
            @(negedge axis_clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL tready_timeout: got tready=0 expected 1 within 20 cycles");
        end
        @(posedge axis_clk);
        last_acc_t = $time;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge axis_clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic push_exp(input logic cam);
        exp_t e;
        e.den = cam;   e.aen = ~cam;
        e.daddr = m_daddr; e.din = m_din; e.mask = m_mask;
        e.aaddr = m_aaddr; e.act = m_act; e.wr = m_wr;
        exp_q.push_back(e);
    endtask

    task automatic send_act(input logic [3:0] addr, input logic [24:0] data);
        m_aaddr = addr; m_act = data; m_wr++;
        push_exp(1'b0);
        beat(hdr(8'd0, 4'd1, addr), 1'b0, 0);
        beat({231'h0, data}, 1'b1, 0);
        idle(2);
    endtask

    task automatic send_cam(input logic [3:0] addr, input int base, input bit gaps);
        logic [1023:0] d, m;
        for (int k = 0; k < 4; k++) begin
            d[k*256 +: 256] = pat(base + k);
            m[k*256 +: 256] = pat(base + 4 + k);
        end
        m_din = d; m_mask = m; m_daddr = addr; m_wr++;
        push_exp(1'b1);
        beat(hdr(8'd0, 4'd0, addr), 1'b0, 0);
        for (int k = 0; k < 8; k++)
            beat(k < 4 ? d[k*256 +: 256] : m[(k-4)*256 +: 256], k == 7, gaps ? (k % 2) : 0);
        idle(2);
    endtask

    task automatic check_outputs(input string tag);
        chk_wide({tag, "_din"}, lookup_din, m_din);
        chk_wide({tag, "_mask"}, lookup_din_mask, m_mask);
        chk({tag, "_cam_addr"}, 64'(lookup_din_addr), 64'(m_daddr));
        chk({tag, "_act_addr"}, 64'(action_addr), 64'(m_aaddr));
        chk({tag, "_act_data"}, 64'(action_data_in), 64'(m_act));
        chk({tag, "_wr_cnt"}, 64'(cfg_wr_cnt), 64'(m_wr));
        chk({tag, "_err_cnt"}, 64'(cfg_err_cnt), 64'(m_err));
        chk({tag, "_strobes"}, {62'd0, lookup_din_en, action_en}, 64'd0);
        chk({tag, "_tready"}, 64'(s_axis_tready), 64'd1);
    endtask

    task automatic model_reset();
        m_din = '0; m_mask = '0; m_daddr = '0; m_aaddr = '0;
        m_act = '0; m_wr = '0; m_err = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        model_reset();
        repeat (3) @(negedge axis_clk);
        check_outputs("reset");
        aresetn = 1'b1;
        idle(2);

        // Action write to addr 3
        send_act(4'd3, 25'h1ABCDE);
        check_outputs("after_act");

        // CAM write to addr 15, back-to-back beats
        send_cam(4'd15, 16'h100, 1'b0);
        check_outputs("after_cam");

        // Foreign stage, 9 beats: drained, nothing changes
        beat(hdr(8'd5, 4'd0, 4'd2), 1'b0, 0);
        for (int k = 0; k < 8; k++) beat(pat(16'h500 + k), k == 7, 0);
        idle(2);
        check_outputs("foreign");

        // Early tlast on CAM data beat 2
        beat(hdr(8'd0, 4'd0, 4'd6), 1'b0, 0);
        beat(pat(16'h600), 1'b0, 0);
        beat(pat(16'h601), 1'b1, 0);
        m_err++;
        idle(2);
        check_outputs("early_tlast");
        send_act(4'd7, 25'h0055AA1);
        check_outputs("act_after_err");

        // Too-long action packet: third beat drained
        beat(hdr(8'd0, 4'd1, 4'd9), 1'b0, 0);
        beat({231'h0, 25'h1FFFFFF}, 1'b0, 0);
        beat(pat(16'h900), 1'b1, 0);
        m_err++;
        idle(2);
        check_outputs("too_long");

        // Header-only packet for this stage, then a bad type with one trailing beat
        beat(hdr(8'd0, 4'd1, 4'd1), 1'b1, 0);
        m_err++;
        beat(hdr(8'd0, 4'd2, 4'd1), 1'b0, 0);
        beat(pat(16'hA00), 1'b1, 0);
        m_err++;
        idle(2);
        check_outputs("bad_hdr");

        // CAM write with tvalid toggling
        send_cam(4'd5, 16'h200, 1'b1);
        check_outputs("cam_gaps");

        // Reset pulsed mid-CAM packet
        beat(hdr(8'd0, 4'd0, 4'd12), 1'b0, 0);
        for (int k = 0; k < 4; k++) beat(pat(16'hC00 + k), 1'b0, 0);
        @(negedge axis_clk);
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b0;
        model_reset();
        #1;
        check_outputs("in_reset");
        @(negedge axis_clk);
        aresetn = 1'b1;
        idle(2);
        check_outputs("after_reset");

        // Recovery: writer starts again from IDLE
        send_act(4'd2, 25'h0000155);
        check_outputs("recovered");

        idle(3);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
